// File: rtl/mem_burst_ctrl.sv
// Burst sequencer in front of a single-port memory (mem_para).
// Accepts one burst command at a time, then streams write beats into the
// memory or streams read beats out of it. Addresses wrap modulo DEPTH.
// All memory-side signals are registered; mem_data_out is sampled one
// cycle after mem_addr changes, which covers a registered-read memory.
module mem_burst_ctrl #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 4,
   parameter int DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [ADDR_WIDTH:0]   cmd_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_wr_enable,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WRITE  = 3'd1;
   localparam logic [2:0] S_READ   = 3'd2;
   localparam logic [2:0] S_RDRAIN = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   // DEPTH widened by one bit so DEPTH == 2**ADDR_WIDTH still compares correctly
   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH-1);
   localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH+1)'(1);

   logic [2:0]            state_reg;
   logic [ADDR_WIDTH-1:0] cur_addr_reg;
   logic [ADDR_WIDTH:0]   remaining_reg;
   logic                  reject_reg;   // the command in DONE was refused
   logic                  settled_reg;  // mem_data_out reflects mem_addr

   logic                  cmd_fire;
   logic                  wr_fire;
   logic                  rd_capture;
   logic [ADDR_WIDTH-1:0] next_addr;

   assign cmd_ready = (state_reg == S_IDLE);
   assign wr_ready  = (state_reg == S_WRITE);
   assign busy      = (state_reg != S_IDLE);
   assign done      = (state_reg == S_DONE);
   assign err       = (state_reg == S_DONE) && reject_reg;

   assign cmd_fire   = cmd_valid && (state_reg == S_IDLE);
   assign wr_fire    = wr_valid && (state_reg == S_WRITE);
   // A new read beat may only be loaded when the output slot is free or being drained
   assign rd_capture = (state_reg == S_READ) && settled_reg && (!rd_valid || rd_ready);
   // Wrap at DEPTH rather than at the natural power-of-two boundary
   assign next_addr  = (cur_addr_reg == LAST_ADDR) ? '0 : cur_addr_reg + ADDR_WIDTH'(1);

   // Burst FSM together with the registered memory and read-beat outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         cur_addr_reg  <= '0;
         remaining_reg <= '0;
         reject_reg    <= 1'b0;
         settled_reg   <= 1'b0;
         mem_addr      <= '0;
         mem_data_in   <= '0;
         mem_wr_enable <= 1'b0;
         rd_valid      <= 1'b0;
         rd_data       <= '0;
      end else begin
         // The strobe only ever follows an accepted write beat
         mem_wr_enable <= wr_fire;
         case (state_reg)
            S_IDLE: begin
               if (cmd_fire) begin
                  cur_addr_reg  <= cmd_addr;
                  remaining_reg <= cmd_len;
                  reject_reg    <= 1'b0;
                  if (cmd_len == '0) begin
                     state_reg <= S_DONE;
                  end else if ({1'b0, cmd_addr} >= DEPTH_W) begin
                     reject_reg <= 1'b1;
                     state_reg  <= S_DONE;
                  end else if (cmd_write) begin
                     state_reg <= S_WRITE;
                  end else begin
                     mem_addr    <= cmd_addr;
                     settled_reg <= 1'b0;
                     state_reg   <= S_READ;
                  end
               end
            end
            S_WRITE: begin
               if (wr_fire) begin
                  mem_addr      <= cur_addr_reg;
                  mem_data_in   <= wr_data;
                  cur_addr_reg  <= next_addr;
                  remaining_reg <= remaining_reg - LEN_ONE;
                  if (remaining_reg == LEN_ONE) begin
                     state_reg <= S_DONE;
                  end
               end
            end
            S_READ: begin
               if (rd_capture) begin
                  rd_data  <= mem_data_out;
                  rd_valid <= 1'b1;
                  if (remaining_reg > LEN_ONE) begin
                     cur_addr_reg  <= next_addr;
                     mem_addr      <= next_addr;
                     remaining_reg <= remaining_reg - LEN_ONE;
                     settled_reg   <= 1'b0;
                  end else begin
                     state_reg <= S_RDRAIN;
                  end
               end else begin
                  settled_reg <= 1'b1;
                  if (rd_ready) begin
                     rd_valid <= 1'b0;
                  end
               end
            end
            S_RDRAIN: begin
               if (rd_ready) begin
                  rd_valid  <= 1'b0;
                  state_reg <= S_DONE;
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
Burst sequencer that sits directly upstream of the team's parameterised single-port memory (mem_para) and drives its addr/data_in/wr_enable port. It accepts a burst command over a valid/ready handshake, then streams write beats into the memory or streams read beats out of it. Addresses increment per beat and wrap modulo DEPTH. It turns the memory's raw level-sensitive port into clean, registered, handshaked traffic.

Parameters:
ADDR_WIDTH, 3, memory address width; must match the memory.
DATA_WIDTH, 4, data word width; must match the memory.
DEPTH, 8, number of valid memory words; requires DEPTH <= 2**ADDR_WIDTH.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  burst command valid.
cmd_ready  out  1  controller can accept a command (high only in IDLE).
cmd_write  in  1  1 = write burst, 0 = read burst.
cmd_addr  in  ADDR_WIDTH  start address.
cmd_len  in  ADDR_WIDTH+1  beat count, 0..2**ADDR_WIDTH.
wr_valid  in  1  write beat valid.
wr_ready  out  1  write beat accepted when wr_valid and wr_ready are both high.
wr_data  in  DATA_WIDTH  write beat data.
rd_valid  out  1  read beat valid.
rd_ready  in  1  downstream accepts the read beat.
rd_data  out  DATA_WIDTH  read beat data.
mem_addr  out  ADDR_WIDTH  to memory addr; registered.
mem_data_in  out  DATA_WIDTH  to memory data_in; registered.
mem_wr_enable  out  1  to memory wr_enable; registered.
mem_data_out  in  DATA_WIDTH  from memory data_out.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse at burst end.
err  out  1  one-cycle pulse coincident with done when the command was rejected.

Behaviour:
- Reset: state is IDLE. All registered outputs are cleared: mem_addr=0, mem_data_in=0, mem_wr_enable=0, rd_valid=0, rd_data=0, done=0, err=0. Any in-flight burst is abandoned with no done pulse. The write strobe is cleared at the reset edge.
- States are IDLE, WRITE, READ, RDRAIN and DONE.
- IDLE: cmd_ready=1. A handshake latches cur_addr=cmd_addr, remaining=cmd_len and dir=cmd_write.
  - cmd_len==0 -> DONE with err=0; the memory is not touched.
  - cmd_addr>=DEPTH -> DONE with err=1; the memory is not touched.
  - Otherwise -> WRITE or READ, according to dir.
- WRITE: wr_ready=1.
  - A beat accepted in cycle N gives mem_addr=cur_addr, mem_data_in=wr_data and mem_wr_enable=1 in cycle N+1.
  - mem_wr_enable is 0 in any cycle that follows a non-accept cycle.
  - cur_addr advances and remaining decrements on each accepted beat.
  - When the last beat is accepted -> DONE. Its write strobe is visible during the DONE cycle.
- Address advance: next = (cur_addr==DEPTH-1) ? 0 : cur_addr+1. This wraps at DEPTH, not at 2**ADDR_WIDTH.
- READ:
  - On entry, mem_addr=cur_addr and mem_wr_enable=0 are registered.
  - mem_data_out is treated as valid in the cycle after mem_addr updates.
  - Capture condition: (!rd_valid || rd_ready) and the data is settled. On capture, rd_data<=mem_data_out, rd_valid<=1, and mem_addr advances while remaining>1.
  - This gives a 2-cycle latency from command accept to the first rd_valid.
  - With rd_ready held high, throughput is 1 beat per 2 cycles.
  - When the last beat is captured -> RDRAIN.
- RDRAIN: hold rd_valid/rd_data until rd_ready is seen, then rd_valid<=0 -> DONE.
- Read handshake rule: rd_data is stable while rd_valid=1 and rd_ready=0.
- DONE: done=1 (plus err if the command was rejected), busy=1 and cmd_ready=0 for one cycle, then -> IDLE.
- wr_ready=0 outside WRITE. Write beats offered outside WRITE are ignored.
- A burst with cmd_len>DEPTH wraps and overwrites or re-reads earlier addresses. This is legal and not an error.

Test Plan:
- Reset check: assert rst for 2 cycles with random inputs -> all outputs 0, cmd_ready=1, busy=0.
- Write burst: cmd write, addr=2, len=3, beats 0xA, 0xB, 0xC with wr_valid held high -> mem_wr_enable high for 3 consecutive cycles with mem_addr 2, 3, 4 and data A, B, C, then a done pulse.
- Readback with backpressure: read, addr=2, len=3, with rd_ready toggling 1,0,0,1,... -> rd_data A, B, C in order, held stable while stalled, then done. mem_wr_enable never goes high.
- Wrap: write addr=6, len=4 with data 1, 2, 3, 4 -> mem_addr 6, 7, 0, 1; a read at addr=6, len=4 returns 1, 2, 3, 4.
- Rejects: len=0 -> done=1, err=0 with no memory activity. With DEPTH=6, addr=7 -> done=1, err=1 with no memory activity. With DEPTH=6, a burst from addr 5 wraps to 0.
- Reset mid-burst: assert rst after 1 of 4 write beats -> next cycle state is IDLE, mem_wr_enable=0, no done pulse; a new command is accepted normally.
